mem_arbiter: RTL and testbench

- Sequences and shares one single-port memory between the instruction-fetch path (PC/controlleur) and the load/store data path (reg_bench/ALU).
- Arbitrates the two requesters and drives a ready/ack memory handshake.
- Detects misaligned accesses and memory timeouts, and returns per-requester read data with a one-cycle done pulse.
- Sits between the core (controlleur, PC, reg_bench) and the RAM.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store traffic,
// with starvation control, misalignment detection and an access timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;
    logic          owner_i;
    logic          lat_we;
    logic          grant_i;
    logic [31:0]   g_addr;
    logic [31:0]   cap_data;

    // Data normally wins a tie; fetch wins only once the starvation budget is spent.
    always_comb begin
        grant_i  = i_req && (!d_req || starve_cnt == SW'(STARVE_LIMIT));
        g_addr   = grant_i ? i_addr : d_addr;
        cap_data = mem_ack ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            owner_i    <= 1'b0;
            lat_we     <= 1'b0;
            i_rdata    <= '0;
            i_done     <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_req)
                        starve_cnt <= '0;
                    if (i_req || d_req) begin
                        owner_i <= grant_i;
                        lat_we  <= !grant_i && d_we;
                        busy    <= 1'b1;
                        if (grant_i)
                            starve_cnt <= '0;
                        else if (i_req && starve_cnt != SW'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + SW'(1);
                        if (g_addr[1:0] != 2'b00) begin
                            state  <= DONE;
                            err    <= 1'b1;
                            i_done <= grant_i;
                            d_done <= !grant_i;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_addr  <= g_addr;
                            mem_we    <= !grant_i && d_we;
                            mem_wdata <= grant_i ? '0 : d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    to_cnt <= to_cnt + TW'(1);
                    // An ack in the final allowed cycle still counts as success.
                    if (mem_ack || to_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= !mem_ack;
                        if (owner_i) begin
                            i_done  <= 1'b1;
                            i_rdata <= cap_data;
                        end else begin
                            d_done <= 1'b1;
                            if (!lat_we)
                                d_rdata <= cap_data;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    to_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions and memory
// accesses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_done, d_done, err, busy;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        resp_ack, stray_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    assign mem_ack = resp_ack | stray_ack;

    typedef struct {
        logic        port_d;
        logic        err;
        logic [31:0] i_rd;
        logic [31:0] d_rd;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    done_t       done_q[$];
    acc_t        acc_q[$];
    int          n_chk = 0, n_fail = 0;
    int          done_cnt = 0, done_cyc = 0, cyc = 0;
    int          req_rises = 0, run_len = 0, last_len = 0;
    logic        prev_req = 1'b0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_i = '0, exp_d = '0;
    bit          ack_en;
    int          ack_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: acks ack_lat cycles after seeing mem_req, stores update the array.
    initial begin
        int rcnt;
        rcnt      = 0;
        resp_ack  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !mem_req || !ack_en) begin
                resp_ack = 1'b0;
                rcnt     = 0;
            end else if (rcnt == ack_lat) begin
                resp_ack  = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we)
                    mem[mem_addr[9:2]] = mem_wdata;
                rcnt = 0;
            end else begin
                resp_ack = 1'b0;
                rcnt++;
            end
        end
    end

    // Monitor
    initial begin
        done_t e;
        acc_t  a;
        forever begin
            @(negedge clk);
            if (i_done || d_done) begin
                done_cyc = cyc;
                done_cnt++;
                chk("done_onehot", 32'(i_done & d_done), 32'd0);
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got i_done=%0b d_done=%0b expected none at %0t",
                             i_done, d_done, $time);
                end else begin
                    e = done_q.pop_front();
                    chk("done_port", 32'(d_done), 32'(e.port_d));
                    chk("err", 32'(err), 32'(e.err));
                    chk("i_rdata", i_rdata, e.i_rd);
                    chk("d_rdata", d_rdata, e.d_rd);
                    chk("busy_in_done", 32'(busy), 32'd1);
                end
            end
            if (mem_req && !prev_req) begin
                req_rises++;
                run_len = 1;
                if (acc_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h expected no access at %0t",
                             mem_addr, $time);
                end else begin
                    a = acc_q.pop_front();
                    chk("mem_addr", mem_addr, a.addr);
                    chk("mem_we", 32'(mem_we), 32'(a.we));
                    if (a.we)
                        chk("mem_wdata", mem_wdata, a.wdata);
                end
            end else if (mem_req) begin
                run_len++;
            end else if (prev_req) begin
                last_len = run_len;
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (done_cnt < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({name, "_completed"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic access(input logic is_i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat, input string name);
        int rc;
        int target;
        if (addr[1:0] == 2'b00) begin
            if (is_i)
                exp_i = exp_rd;
            else if (!we)
                exp_d = exp_rd;
            acc_q.push_back('{addr: addr, we: we && !is_i, wdata: wdata});
        end
        done_q.push_back('{port_d: !is_i, err: exp_err, i_rd: exp_i, d_rd: exp_d});
        if (is_i) begin
            i_addr = addr;
            i_req  = 1'b1;
        end else begin
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
            d_req   = 1'b1;
        end
        rc     = cyc;
        target = done_cnt + 1;
        wait_done(target, 40, name);
        chk({name, "_latency"}, 32'(done_cyc - rc), 32'(exp_lat));
        i_req = 1'b0;
        d_req = 1'b0;
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_i_rdata"}, i_rdata, 32'd0);
        chk({name, "_d_rdata"}, d_rdata, 32'd0);
        chk({name, "_mem_addr"}, mem_addr, 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({name, "_flags"}, 32'({i_done, d_done, err, busy, mem_req, mem_we}), 32'd0);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        stray_ack = 1'b0;
        ack_en = 1'b1;
        ack_lat = 0;
        for (int k = 0; k < 256; k++) mem[k] = '0;
        mem[2]  = 32'h2002_0005;
        mem[5]  = 32'h1234_5678;
        mem[16] = 32'h1111_1111;
        mem[32] = 32'h2222_2222;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fetch, ack two cycles after mem_req
        ack_lat = 2;
        access(1'b1, 1'b0, 32'h8, '0, 1'b0, 32'h2002_0005, 4, "fetch");

        // Store then load back
        ack_lat = 0;
        access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, '0, 2, "store");
        access(1'b0, 1'b0, 32'h100, '0, 1'b0, 32'hDEAD_BEEF, 2, "load");

        // Misaligned data access: no memory cycle, d_rdata holds
        r = req_rises;
        access(1'b0, 1'b0, 32'h13, '0, 1'b1, '0, 1, "misaligned");
        chk("misaligned_no_mem_req", 32'(req_rises), 32'(r));

        // Timeout, then ack in the very last allowed cycle
        ack_en = 1'b0;
        access(1'b1, 1'b0, 32'h10, '0, 1'b1, 32'h0, 17, "timeout");
        chk("timeout_req_len", 32'(last_len), 32'd16);
        ack_en = 1'b1;
        ack_lat = 15;
        access(1'b1, 1'b0, 32'h14, '0, 1'b0, 32'h1234_5678, 17, "ack_at_limit");
        chk("ack_at_limit_req_len", 32'(last_len), 32'd16);

        // Contention: grant order D,D,D,D,I,D,D,D,D,I
        ack_lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                exp_i = 32'h1111_1111;
                acc_q.push_back('{addr: 32'h40, we: 1'b0, wdata: '0});
                done_q.push_back('{port_d: 1'b0, err: 1'b0, i_rd: exp_i, d_rd: exp_d});
            end else begin
                exp_d = 32'h2222_2222;
                acc_q.push_back('{addr: 32'h80, we: 1'b0, wdata: '0});
                done_q.push_back('{port_d: 1'b1, err: 1'b0, i_rd: exp_i, d_rd: exp_d});
            end
        end
        i_addr = 32'h40; d_addr = 32'h80; d_we = 1'b0; d_wdata = '0;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(done_cnt + 10, 200, "contention");
        i_req = 1'b0; d_req = 1'b0;

        // Reset three cycles into ACCESS, then a stray ack while idle
        ack_en = 1'b0;
        acc_q.push_back('{addr: 32'h20, we: 1'b0, wdata: '0});
        i_addr = 32'h20;
        i_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        i_req = 1'b0;
        exp_i = '0;
        exp_d = '0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
        ack_en = 1'b1;
        ack_lat = 1;
        access(1'b1, 1'b0, 32'h8, '0, 1'b0, 32'h2002_0005, 3, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        chk("acc_q_empty", 32'(acc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
